// File: rtl/mem_stage_ctl.sv
// mem_stage_ctl: pipeline MEM stage; performs data-memory loads/stores over req/ack and fills the MEM/WB register.
// Latency: non-memory ops 1 cycle; memory ops 2 cycles when acked in the first BUSY cycle, +1 per un-acked cycle.
// Backpressure: Stall_OUT (combinational) holds upstream from op arrival until the cycle DMem_ack_IN is seen.
// Ports: CLK / RESET (async, active-low); *_IN = EXE/MEM register fields; DMem_* = data-memory req/ack port;
//        *_OUT = MEM/WB register fields, Fwd_MEM_WriteData_OUT = MEM forwarding source; Stall_OUT, Misaligned_OUT.
// Option: define MEM_SUBWORD_EN for big-endian byte/halfword accesses; when undefined every access is a word.
module mem_stage_ctl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  output logic        DMem_req_OUT,
  output logic        DMem_we_OUT,
  output logic [31:0] DMem_addr_OUT,
  output logic [31:0] DMem_wdata_OUT,
  output logic [3:0]  DMem_be_OUT,
  input  logic        DMem_ack_IN,
  input  logic [31:0] DMem_rdata_IN,
  output logic        Stall_OUT,
  output logic        Misaligned_OUT,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output logic [31:0] Fwd_MEM_WriteData_OUT
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  // Held memory request (address stored word-aligned)
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  // Instruction fields held while the access is outstanding
  logic [31:0] pend_instr_q, pend_instr_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [4:0]  pend_wreg_q, pend_wreg_d;
  logic        pend_regw_q, pend_regw_d;
  // MEM/WB register
  logic [31:0] wb_instr_q, wb_instr_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_wreg_q, wb_wreg_d;
  logic        wb_regw_q, wb_regw_d;
  logic        mis_q, mis_d;

  logic        mem_op, misaligned, stall;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_data;

  assign mem_op = MemRead1_IN | MemWrite1_IN;

`ifdef MEM_SUBWORD_EN
  localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28, OP_SH  = 6'h29;

  logic [5:0]  pend_op_q, pend_op_d;
  logic [1:0]  pend_off_q, pend_off_d;
  logic [1:0]  acc_size;   // 0 = byte, 1 = halfword, 2 = word (also unknown codes)
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store formatting: data replicated to every lane, byte enables select the lane(s).
  always_comb begin
    acc_size = 2'd2;
    case (ALU_Control1_IN)
      OP_LB, OP_LBU, OP_SB: acc_size = 2'd0;
      OP_LH, OP_LHU, OP_SH: acc_size = 2'd1;
      default:              acc_size = 2'd2;
    endcase
    misaligned = |ALU_result1_IN[1:0];
    st_be      = 4'b1111;
    st_data    = MemWriteData1_IN;
    case (acc_size)
      2'd0: begin
        misaligned = 1'b0;
        st_be      = 4'b1000 >> ALU_result1_IN[1:0];  // bit 3 is byte offset 0
        st_data    = {4{MemWriteData1_IN[7:0]}};
      end
      2'd1: begin
        misaligned = ALU_result1_IN[0];
        st_be      = ALU_result1_IN[1] ? 4'b0011 : 4'b1100;
        st_data    = {2{MemWriteData1_IN[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction, big-endian: byte offset 0 lives in rdata[31:24].
  always_comb begin
    ld_byte = DMem_rdata_IN[31:24];
    case (pend_off_q)
      2'd1:    ld_byte = DMem_rdata_IN[23:16];
      2'd2:    ld_byte = DMem_rdata_IN[15:8];
      2'd3:    ld_byte = DMem_rdata_IN[7:0];
      default: ld_byte = DMem_rdata_IN[31:24];
    endcase
    ld_half = pend_off_q[1] ? DMem_rdata_IN[15:0] : DMem_rdata_IN[31:16];
    case (pend_op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = DMem_rdata_IN;
    endcase
  end
`else
  // Word-only build: the access-type code has no effect.
  logic unused_ctl;
  assign unused_ctl = ^ALU_Control1_IN;
  assign misaligned = |ALU_result1_IN[1:0];
  assign st_be      = 4'b1111;
  assign st_data    = MemWriteData1_IN;
  assign ld_data    = DMem_rdata_IN;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    pend_instr_d = pend_instr_q;
    pend_pc_d    = pend_pc_q;
    pend_wreg_d  = pend_wreg_q;
    pend_regw_d  = pend_regw_q;
`ifdef MEM_SUBWORD_EN
    pend_op_d    = pend_op_q;
    pend_off_d   = pend_off_q;
`endif
    // MEM/WB defaults to a bubble; only real results override it.
    wb_instr_d   = 32'd0;
    wb_pc_d      = 32'd0;
    wb_data_d    = 32'd0;
    wb_wreg_d    = 5'd0;
    wb_regw_d    = 1'b0;
    mis_d        = 1'b0;
    stall        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op && misaligned) begin
          mis_d = 1'b1;               // dropped: no request, no stall
        end else if (mem_op) begin
          stall        = 1'b1;
          addr_d       = ALU_result1_IN[31:2];
          wdata_d      = st_data;
          be_d         = st_be;
          we_d         = MemWrite1_IN;
          pend_instr_d = Instr1_IN;
          pend_pc_d    = Instr1_PC_IN;
          pend_wreg_d  = WriteRegister1_IN;
          pend_regw_d  = RegWrite1_IN & ~MemWrite1_IN;
`ifdef MEM_SUBWORD_EN
          pend_op_d    = ALU_Control1_IN;
          pend_off_d   = ALU_result1_IN[1:0];
`endif
          state_d      = S_BUSY;
        end else begin
          wb_instr_d = Instr1_IN;
          wb_pc_d    = Instr1_PC_IN;
          wb_data_d  = ALU_result1_IN;
          wb_wreg_d  = WriteRegister1_IN;
          wb_regw_d  = RegWrite1_IN;
        end
      end
      S_BUSY: begin
        if (DMem_ack_IN) begin
          wb_instr_d = pend_instr_q;
          wb_pc_d    = pend_pc_q;
          wb_data_d  = ld_data;
          wb_wreg_d  = pend_wreg_q;
          wb_regw_d  = pend_regw_q;
          state_d    = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      addr_q       <= 30'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      we_q         <= 1'b0;
      pend_instr_q <= 32'd0;
      pend_pc_q    <= 32'd0;
      pend_wreg_q  <= 5'd0;
      pend_regw_q  <= 1'b0;
`ifdef MEM_SUBWORD_EN
      pend_op_q    <= 6'd0;
      pend_off_q   <= 2'd0;
`endif
      wb_instr_q   <= 32'd0;
      wb_pc_q      <= 32'd0;
      wb_data_q    <= 32'd0;
      wb_wreg_q    <= 5'd0;
      wb_regw_q    <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      we_q         <= we_d;
      pend_instr_q <= pend_instr_d;
      pend_pc_q    <= pend_pc_d;
      pend_wreg_q  <= pend_wreg_d;
      pend_regw_q  <= pend_regw_d;
`ifdef MEM_SUBWORD_EN
      pend_op_q    <= pend_op_d;
      pend_off_q   <= pend_off_d;
`endif
      wb_instr_q   <= wb_instr_d;
      wb_pc_q      <= wb_pc_d;
      wb_data_q    <= wb_data_d;
      wb_wreg_q    <= wb_wreg_d;
      wb_regw_q    <= wb_regw_d;
      mis_q        <= mis_d;
    end
  end

  assign DMem_req_OUT          = (state_q == S_BUSY);
  assign DMem_we_OUT           = we_q;
  assign DMem_addr_OUT         = {addr_q, 2'b00};
  assign DMem_wdata_OUT        = wdata_q;
  assign DMem_be_OUT           = be_q;
  // Gated by RESET so a mem op sitting on the inputs cannot stall during reset.
  assign Stall_OUT             = stall & RESET;
  assign Misaligned_OUT        = mis_q;
  assign Instr1_OUT            = wb_instr_q;
  assign Instr1_PC_OUT         = wb_pc_q;
  assign WriteData1_OUT        = wb_data_q;
  assign WriteRegister1_OUT    = wb_wreg_q;
  assign RegWrite1_OUT         = wb_regw_q;
  assign Fwd_MEM_WriteData_OUT = wb_data_q;

endmodule

// File: tb/tb_mem_stage_ctl.sv
module tb_mem_stage_ctl;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B, OP_ADD = 6'h01, OP_UNK = 6'h3F;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        DMem_req_OUT, DMem_we_OUT;
  logic [31:0] DMem_addr_OUT, DMem_wdata_OUT;
  logic [3:0]  DMem_be_OUT;
  logic        DMem_ack_IN;
  logic [31:0] DMem_rdata_IN;
  logic        Stall_OUT, Misaligned_OUT;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, Fwd_MEM_WriteData_OUT;
  logic [4:0]  WriteRegister1_OUT;
  logic        RegWrite1_OUT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_stage_ctl dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN), .ALU_result1_IN(ALU_result1_IN),
    .WriteRegister1_IN(WriteRegister1_IN), .MemWriteData1_IN(MemWriteData1_IN),
    .RegWrite1_IN(RegWrite1_IN), .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN),
    .DMem_req_OUT(DMem_req_OUT), .DMem_we_OUT(DMem_we_OUT), .DMem_addr_OUT(DMem_addr_OUT),
    .DMem_wdata_OUT(DMem_wdata_OUT), .DMem_be_OUT(DMem_be_OUT),
    .DMem_ack_IN(DMem_ack_IN), .DMem_rdata_IN(DMem_rdata_IN),
    .Stall_OUT(Stall_OUT), .Misaligned_OUT(Misaligned_OUT),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT), .WriteData1_OUT(WriteData1_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
    .Fwd_MEM_WriteData_OUT(Fwd_MEM_WriteData_OUT)
  );

  // Expected MEM/WB contents; every real (non-bubble) result carries a nonzero instruction word.
  typedef struct {
    logic [31:0] instr, pc, data;
    logic [4:0]  wreg;
    logic        regw, chk;
  } wb_t;

  typedef struct {
    logic [5:0]  ctl;
    logic        mr, mw, mis;
    logic [31:0] addr, wd, rd, exp_data, exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  wb_t sb_q[$];
  wb_t mon_e;

  function automatic wb_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] data,
                             input logic [4:0] wreg, input logic regw, input logic chk);
    wb_t e;
    e.instr = instr; e.pc = pc; e.data = data; e.wreg = wreg; e.regw = regw; e.chk = chk;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [5:0] ctl, input logic mr, input logic mw, input logic mis,
                               input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                               input logic [31:0] exp_data, input logic [31:0] exp_wdata, input logic [3:0] exp_be);
    vec_t v;
    v.ctl = ctl; v.mr = mr; v.mw = mw; v.mis = mis; v.addr = addr; v.wd = wd; v.rd = rd;
    v.exp_data = exp_data; v.exp_wdata = exp_wdata; v.exp_be = exp_be;
    return v;
  endfunction

  // Scoreboard: pop and compare whenever the MEM/WB register holds a real instruction.
  always @(negedge CLK) begin
    if (RESET === 1'b1 && Instr1_OUT !== 32'd0) begin
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL wb_unexpected: got instr %h data %h, expected no result", Instr1_OUT, WriteData1_OUT);
      end else begin
        mon_e = sb_q.pop_front();
        if (Instr1_OUT !== mon_e.instr || Instr1_PC_OUT !== mon_e.pc || RegWrite1_OUT !== mon_e.regw
            || (mon_e.regw && WriteRegister1_OUT !== mon_e.wreg)
            || (mon_e.chk && (WriteData1_OUT !== mon_e.data || Fwd_MEM_WriteData_OUT !== mon_e.data))) begin
          errors = errors + 1;
          $display("FAIL wb_result: got instr %h pc %h data %h fwd %h rd %0d rw %b, expected instr %h pc %h data %h rd %0d rw %b",
                   Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, Fwd_MEM_WriteData_OUT, WriteRegister1_OUT, RegWrite1_OUT,
                   mon_e.instr, mon_e.pc, mon_e.data, mon_e.wreg, mon_e.regw);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [4:0] wreg, input logic [31:0] wd, input logic rw, input logic mr,
                       input logic mw, input logic [5:0] ctl);
    Instr1_IN = instr; Instr1_PC_IN = pc; ALU_result1_IN = alu; WriteRegister1_IN = wreg;
    MemWriteData1_IN = wd; RegWrite1_IN = rw; MemRead1_IN = mr; MemWrite1_IN = mw; ALU_Control1_IN = ctl;
  endtask

  task automatic idle();
    drive(32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic test_reset();
    #12;
    @(negedge CLK);
    checks = checks + 1;
    if (DMem_req_OUT !== 1'b0 || Stall_OUT !== 1'b0 || Misaligned_OUT !== 1'b0 || RegWrite1_OUT !== 1'b0
        || WriteData1_OUT !== 32'd0 || Instr1_OUT !== 32'd0 || DMem_addr_OUT !== 32'd0 || DMem_be_OUT !== 4'd0) begin
      errors = errors + 1;
      $display("FAIL reset_state: req %b stall %b mis %b rw %b data %h instr %h addr %h be %b, expected all 0",
               DMem_req_OUT, Stall_OUT, Misaligned_OUT, RegWrite1_OUT, WriteData1_OUT, Instr1_OUT, DMem_addr_OUT, DMem_be_OUT);
    end
    // A load presented while reset is held must not stall or request.
    drive(32'h8c00_0001, 32'h4, 32'h100, 5'd3, 32'd0, 1'b1, 1'b1, 1'b0, OP_LW);
    #1;
    checks = checks + 1;
    if (Stall_OUT !== 1'b0 || DMem_req_OUT !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_no_stall: stall %b req %b, expected 0 0", Stall_OUT, DMem_req_OUT);
    end
    @(negedge CLK);
    idle();
    RESET = 1'b1;
  endtask

  task automatic test_alu();
    @(negedge CLK);
    drive(32'h0085_1020, 32'h10, 32'h0000_1234, 5'd2, 32'd0, 1'b1, 1'b0, 1'b0, OP_ADD);
    sb_q.push_back(mk(32'h0085_1020, 32'h10, 32'h0000_1234, 5'd2, 1'b1, 1'b1));
    #1;
    checks = checks + 1;
    if (Stall_OUT !== 1'b0 || DMem_req_OUT !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL alu_no_stall: stall %b req %b, expected 0 0", Stall_OUT, DMem_req_OUT);
    end
    @(negedge CLK);
    idle();
    checks = checks + 1;
    if (WriteData1_OUT !== 32'h0000_1234 || RegWrite1_OUT !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL alu_latency: data %h rw %b one edge after issue, expected 00001234 1", WriteData1_OUT, RegWrite1_OUT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        rw;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      alu = $urandom;
      wr  = 5'($urandom_range(1, 31));
      rw  = 1'($urandom_range(0, 1));
      drive(32'h1000 + 32'(i), 32'h100 + 32'(4 * i), alu, wr, 32'd0, rw, 1'b0, 1'b0, OP_ADD);
      sb_q.push_back(mk(32'h1000 + 32'(i), 32'h100 + 32'(4 * i), alu, wr, rw, 1'b1));
      #1;
      checks = checks + 1;
      if (Stall_OUT !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL b2b_stall[%0d]: stall %b, expected 0", i, Stall_OUT);
      end
    end
    @(negedge CLK);
    idle();
  endtask

  task automatic test_lw();
    @(negedge CLK);
    drive(32'h8c00_0100, 32'h40, 32'h100, 5'd7, 32'd0, 1'b1, 1'b1, 1'b0, OP_LW);
    sb_q.push_back(mk(32'h8c00_0100, 32'h40, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b1));
    #1;
    checks = checks + 1;
    if (Stall_OUT !== 1'b1 || DMem_req_OUT !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL lw_arrival: stall %b req %b, expected 1 0", Stall_OUT, DMem_req_OUT);
    end
    @(negedge CLK);
    checks = checks + 1;
    if (DMem_req_OUT !== 1'b1 || DMem_addr_OUT !== 32'h100 || DMem_we_OUT !== 1'b0 || DMem_be_OUT !== 4'b1111
        || RegWrite1_OUT !== 1'b0 || Instr1_OUT !== 32'd0) begin
      errors = errors + 1;
      $display("FAIL lw_busy: req %b addr %h we %b be %b rw %b instr %h, expected 1 00000100 0 1111 0 0",
               DMem_req_OUT, DMem_addr_OUT, DMem_we_OUT, DMem_be_OUT, RegWrite1_OUT, Instr1_OUT);
    end
    DMem_ack_IN = 1'b1;
    DMem_rdata_IN = 32'hDEAD_BEEF;
    #1;
    checks = checks + 1;
    if (Stall_OUT !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL lw_ack_stall: stall %b in ack cycle, expected 0", Stall_OUT);
    end
    @(negedge CLK);
    DMem_ack_IN = 1'b0;
    idle();
    checks = checks + 1;
    if (WriteData1_OUT !== 32'hDEAD_BEEF || DMem_req_OUT !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL lw_result: data %h req %b two edges after arrival, expected deadbeef 0", WriteData1_OUT, DMem_req_OUT);
    end
  endtask

  task automatic test_store_delayed();
    logic [31:0] addr, exp_addr, exp_wdata;
    logic [5:0]  ctl;
    logic [3:0]  exp_be;
    int stall_cnt, req_cnt;
`ifdef MEM_SUBWORD_EN
    ctl = OP_SB; addr = 32'h101; exp_addr = 32'h100; exp_wdata = 32'hABAB_ABAB; exp_be = 4'b0100;
`else
    ctl = OP_SW; addr = 32'h104; exp_addr = 32'h104; exp_wdata = 32'h0000_00AB; exp_be = 4'b1111;
`endif
    stall_cnt = 0;
    req_cnt = 0;
    @(negedge CLK);
    drive(32'hA000_0001, 32'h80, addr, 5'd4, 32'h0000_00AB, 1'b0, 1'b0, 1'b1, ctl);
    sb_q.push_back(mk(32'hA000_0001, 32'h80, 32'd0, 5'd4, 1'b0, 1'b0));
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        DMem_ack_IN = 1'b1;
        DMem_rdata_IN = 32'h5555_5555;
      end
      #1;
      if (Stall_OUT === 1'b1) stall_cnt++;
      if (DMem_req_OUT === 1'b1) req_cnt++;
      if (c == 1) begin
        checks = checks + 1;
        if (DMem_addr_OUT !== exp_addr || DMem_wdata_OUT !== exp_wdata || DMem_be_OUT !== exp_be || DMem_we_OUT !== 1'b1) begin
          errors = errors + 1;
          $display("FAIL st_format: addr %h wdata %h be %b we %b, expected %h %h %b 1",
                   DMem_addr_OUT, DMem_wdata_OUT, DMem_be_OUT, DMem_we_OUT, exp_addr, exp_wdata, exp_be);
        end
      end
      if (c == 3) begin
        checks = checks + 1;
        if (Stall_OUT !== 1'b0 || DMem_req_OUT !== 1'b1) begin
          errors = errors + 1;
          $display("FAIL st_ack_cycle: stall %b req %b, expected 0 1", Stall_OUT, DMem_req_OUT);
        end
      end
      @(negedge CLK);
    end
    DMem_ack_IN = 1'b0;
    idle();
    checks = checks + 1;
    if (stall_cnt != 3 || req_cnt != 3) begin
      errors = errors + 1;
      $display("FAIL st_hold_cycles: stall cycles %0d req cycles %0d, expected 3 3", stall_cnt, req_cnt);
    end
  endtask

  task automatic test_access_types();
    vec_t tv[$];
`ifdef MEM_SUBWORD_EN
    tv.push_back(mkv(OP_LB,  1, 0, 0, 32'h103, 0, 32'h1234_56F0, 32'hFFFF_FFF0, 0, 4'b0001));
    tv.push_back(mkv(OP_LBU, 1, 0, 0, 32'h103, 0, 32'h1234_56F0, 32'h0000_00F0, 0, 4'b0001));
    tv.push_back(mkv(OP_LH,  1, 0, 0, 32'h102, 0, 32'h1234_8001, 32'hFFFF_8001, 0, 4'b0011));
    tv.push_back(mkv(OP_LHU, 1, 0, 0, 32'h100, 0, 32'h8001_1234, 32'h0000_8001, 0, 4'b1100));
    tv.push_back(mkv(OP_LB,  1, 0, 0, 32'h100, 0, 32'h80FF_FFFF, 32'hFFFF_FF80, 0, 4'b1000));
    tv.push_back(mkv(OP_LBU, 1, 0, 0, 32'h101, 0, 32'h00A5_0000, 32'h0000_00A5, 0, 4'b0100));
    tv.push_back(mkv(OP_SH,  0, 1, 0, 32'h102, 32'h1234_ABCD, 0, 0, 32'hABCD_ABCD, 4'b0011));
    tv.push_back(mkv(OP_SH,  0, 1, 0, 32'h100, 32'h1234_ABCD, 0, 0, 32'hABCD_ABCD, 4'b1100));
    tv.push_back(mkv(OP_SB,  0, 1, 0, 32'h103, 32'h0000_005A, 0, 0, 32'h5A5A_5A5A, 4'b0001));
    tv.push_back(mkv(OP_LH,  1, 0, 1, 32'h101, 0, 0, 0, 0, 0));
    tv.push_back(mkv(OP_SW,  0, 1, 1, 32'h106, 32'h1, 0, 0, 0, 0));
    tv.push_back(mkv(OP_UNK, 1, 0, 0, 32'h100, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 4'b1111));
    tv.push_back(mkv(OP_UNK, 1, 0, 1, 32'h102, 0, 0, 0, 0, 0));
`else
    tv.push_back(mkv(OP_LB,  1, 0, 1, 32'h103, 0, 0, 0, 0, 0));
    tv.push_back(mkv(OP_LB,  1, 0, 0, 32'h100, 0, 32'h1234_56F0, 32'h1234_56F0, 0, 4'b1111));
    tv.push_back(mkv(OP_LH,  1, 0, 1, 32'h102, 0, 0, 0, 0, 0));
    tv.push_back(mkv(OP_LHU, 1, 0, 0, 32'h100, 0, 32'h8001_1234, 32'h8001_1234, 0, 4'b1111));
    tv.push_back(mkv(OP_SB,  0, 1, 0, 32'h100, 32'h0000_00AB, 0, 0, 32'h0000_00AB, 4'b1111));
    tv.push_back(mkv(OP_SW,  0, 1, 0, 32'h104, 32'h1122_3344, 0, 0, 32'h1122_3344, 4'b1111));
    tv.push_back(mkv(OP_UNK, 1, 0, 0, 32'h100, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 4'b1111));
    tv.push_back(mkv(OP_UNK, 1, 0, 1, 32'h102, 0, 0, 0, 0, 0));
`endif
    foreach (tv[i]) begin
      @(negedge CLK);
      drive(32'h0100_0000 + 32'(i), 32'h200 + 32'(4 * i), tv[i].addr, 5'(i + 1), tv[i].wd,
            tv[i].mr, tv[i].mr, tv[i].mw, tv[i].ctl);
      if (!tv[i].mis)
        sb_q.push_back(mk(32'h0100_0000 + 32'(i), 32'h200 + 32'(4 * i), tv[i].exp_data, 5'(i + 1), tv[i].mr, tv[i].mr));
      #1;
      checks = checks + 1;
      if (Stall_OUT !== !tv[i].mis) begin
        errors = errors + 1;
        $display("FAIL acc_stall[%0d]: stall %b, expected %b", i, Stall_OUT, !tv[i].mis);
      end
      @(negedge CLK);
      checks = checks + 1;
      if (tv[i].mis) begin
        if (Misaligned_OUT !== 1'b1 || DMem_req_OUT !== 1'b0 || RegWrite1_OUT !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL acc_misaligned[%0d]: mis %b req %b rw %b, expected 1 0 0", i, Misaligned_OUT, DMem_req_OUT, RegWrite1_OUT);
        end
        idle();
      end else begin
        if (DMem_req_OUT !== 1'b1 || DMem_addr_OUT !== {tv[i].addr[31:2], 2'b00} || DMem_we_OUT !== tv[i].mw
            || (tv[i].mw && (DMem_be_OUT !== tv[i].exp_be || DMem_wdata_OUT !== tv[i].exp_wdata))) begin
          errors = errors + 1;
          $display("FAIL acc_request[%0d]: req %b addr %h we %b be %b wdata %h, expected 1 %h %b %b %h", i,
                   DMem_req_OUT, DMem_addr_OUT, DMem_we_OUT, DMem_be_OUT, DMem_wdata_OUT,
                   {tv[i].addr[31:2], 2'b00}, tv[i].mw, tv[i].exp_be, tv[i].exp_wdata);
        end
        DMem_ack_IN = 1'b1;
        DMem_rdata_IN = tv[i].rd;
        @(negedge CLK);
        DMem_ack_IN = 1'b0;
        idle();
      end
    end
  endtask

  task automatic test_misaligned();
    @(negedge CLK);
    drive(32'h8c00_0202, 32'h60, 32'h102, 5'd9, 32'd0, 1'b1, 1'b1, 1'b0, OP_LW);
    #1;
    checks = checks + 1;
    if (Stall_OUT !== 1'b0 || DMem_req_OUT !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mis_no_stall: stall %b req %b, expected 0 0", Stall_OUT, DMem_req_OUT);
    end
    @(negedge CLK);
    idle();
    checks = checks + 1;
    if (Misaligned_OUT !== 1'b1 || RegWrite1_OUT !== 1'b0 || DMem_req_OUT !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mis_pulse: mis %b rw %b req %b, expected 1 0 0", Misaligned_OUT, RegWrite1_OUT, DMem_req_OUT);
    end
    @(negedge CLK);
    checks = checks + 1;
    if (Misaligned_OUT !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mis_one_cycle: mis %b second cycle, expected 0", Misaligned_OUT);
    end
  endtask

  task automatic test_reset_busy();
    @(negedge CLK);
    drive(32'h8c00_0777, 32'h70, 32'h200, 5'd5, 32'd0, 1'b1, 1'b1, 1'b0, OP_LW);
    @(negedge CLK);
    checks = checks + 1;
    if (DMem_req_OUT !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL rb_busy: req %b before reset, expected 1", DMem_req_OUT);
    end
    #2 RESET = 1'b0;
    #1;
    checks = checks + 1;
    if (DMem_req_OUT !== 1'b0 || Stall_OUT !== 1'b0 || WriteData1_OUT !== 32'd0 || RegWrite1_OUT !== 1'b0
        || Instr1_OUT !== 32'd0 || Misaligned_OUT !== 1'b0 || DMem_addr_OUT !== 32'd0 || DMem_we_OUT !== 1'b0
        || DMem_be_OUT !== 4'd0 || DMem_wdata_OUT !== 32'd0) begin
      errors = errors + 1;
      $display("FAIL rb_reset: req %b stall %b data %h rw %b instr %h mis %b addr %h we %b be %b wdata %h, expected all 0",
               DMem_req_OUT, Stall_OUT, WriteData1_OUT, RegWrite1_OUT, Instr1_OUT, Misaligned_OUT,
               DMem_addr_OUT, DMem_we_OUT, DMem_be_OUT, DMem_wdata_OUT);
    end
    @(negedge CLK);
    idle();
    RESET = 1'b1;
    @(negedge CLK);
    drive(32'h8c00_0888, 32'h300, 32'h300, 5'd9, 32'd0, 1'b1, 1'b1, 1'b0, OP_LW);
    sb_q.push_back(mk(32'h8c00_0888, 32'h300, 32'h1357_9BDF, 5'd9, 1'b1, 1'b1));
    #1;
    checks = checks + 1;
    if (Stall_OUT !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL rb_after_stall: stall %b, expected 1", Stall_OUT);
    end
    @(negedge CLK);
    checks = checks + 1;
    if (DMem_req_OUT !== 1'b1 || DMem_addr_OUT !== 32'h300) begin
      errors = errors + 1;
      $display("FAIL rb_after_req: req %b addr %h, expected 1 00000300", DMem_req_OUT, DMem_addr_OUT);
    end
    DMem_ack_IN = 1'b1;
    DMem_rdata_IN = 32'h1357_9BDF;
    @(negedge CLK);
    DMem_ack_IN = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0;
    DMem_ack_IN = 1'b0;
    DMem_rdata_IN = 32'd0;
    idle();
    test_reset();
    test_alu();
    test_back_to_back();
    test_lw();
    test_store_delayed();
    test_access_types();
    test_misaligned();
    test_reset_busy();
    repeat (2) @(negedge CLK);
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_drain: %0d results never appeared, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctl.md
# mem_stage_ctl

Pipeline MEM stage: receives the EXE/MEM pipeline register fields, performs data-memory loads/stores over a req/ack handshake, and delivers results to the MEM/WB register. It stalls upstream while an access is outstanding and exports the write-back value as the MEM-side forwarding source for EXE operand selection. Sub-word (byte/halfword, big-endian) accesses are a compile-time option.

## Interface
- OP_LB, 6'h20; OP_LH, 6'h21; OP_LW, 6'h23; OP_LBU, 6'h24; OP_LHU, 6'h25 — load codes on ALU_Control1_IN
- OP_SB, 6'h28; OP_SH, 6'h29; OP_SW, 6'h2B — store codes on ALU_Control1_IN
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- Instr1_IN, Instr1_PC_IN  in  32  debug instruction/PC from EXE
- ALU_result1_IN  in  32  effective address, or result for non-memory ops
- WriteRegister1_IN  in  5  destination register
- MemWriteData1_IN  in  32  store data (already forwarded)
- RegWrite1_IN, MemRead1_IN, MemWrite1_IN  in  1  control from EXE
- ALU_Control1_IN  in  6  access-type code
- DMem_req_OUT  out  1  memory request
- DMem_we_OUT  out  1  1 = write
- DMem_addr_OUT  out  32  word-aligned address (bits 1:0 = 0)
- DMem_wdata_OUT  out  32  lane-replicated store data
- DMem_be_OUT  out  4  byte enables, bit 3 = byte offset 0
- DMem_ack_IN  in  1  access complete; rdata valid same cycle
- DMem_rdata_IN  in  32  read word
- Stall_OUT  out  1  combinational; freezes PC/IF/ID/EXE
- Misaligned_OUT  out  1  registered one-cycle pulse
- Instr1_OUT, Instr1_PC_OUT  out  32  to WB
- WriteData1_OUT  out  32  load data or ALU result to WB
- WriteRegister1_OUT  out  5; RegWrite1_OUT  out  1  to WB
- Fwd_MEM_WriteData_OUT  out  32  equals WriteData1_OUT (MEM forwarding source)

## Operation
- FSM IDLE/BUSY. Mem op = MemRead1_IN | MemWrite1_IN.
- IDLE, no mem op: register pass-through (WriteData1_OUT <= ALU_result1_IN) each edge.
- IDLE, mem op, aligned: Stall_OUT=1; capture address, formatted wdata, be, we; go BUSY. MEM/WB gets a bubble (RegWrite1_OUT=0, Instr1_OUT=0).
- BUSY: DMem_req_OUT=1 with held addr/we/wdata/be; Stall_OUT = !DMem_ack_IN; MEM/WB bubble while !ack. On ack: MEM/WB loads instruction fields, WriteData1_OUT <= extracted load data (stores: RegWrite1_OUT=0); go IDLE. Inputs ignored in BUSY.
- Misaligned (halfword addr[0]=1; word addr[1:0]!=0): no request, no stall, RegWrite1_OUT=0, Misaligned_OUT pulses 1 cycle.
- Loads: byte lane = addr[1:0], big-endian; LB/LH sign-extend, LBU/LHU zero-extend.
- Stores: SB replicates byte to 4 lanes, be one-hot; SH replicates halfword, be 4'b1100/4'b0011; SW be 4'b1111.
- Unknown code with mem op treated as word access.

## Timing
- Non-memory op: 1 cycle latency, no stall.
- Memory op: arrival cycle (IDLE, stall), ≥1 BUSY cycle; ack in first BUSY cycle → result at WB 2 edges after arrival; each non-ack cycle adds 1.
- Stall_OUT deasserts in the ack cycle so the next instruction enters on that edge.
- Reset (any state, incl. BUSY): immediately IDLE, DMem_req_OUT=0, all outputs 0, Stall_OUT=0; pending access abandoned.
- DMem_ack_IN ignored in IDLE.

## Configuration
- MEM_SUBWORD_EN defined: byte/halfword handling and alignment as above.
- Undefined: every access is a word access; DMem_be_OUT=4'b1111, no extension/replication; misaligned only if addr[1:0]!=0.

## Test plan
- ADD result 0x0000_1234, RegWrite=1 → WriteData1_OUT=0x1234 after 1 edge, Stall_OUT=0, no req.
- LW addr 0x100, ack in first BUSY cycle, rdata 0xDEADBEEF → Stall high 1 cycle, one bubble, WriteData1_OUT=0xDEADBEEF 2 edges after arrival.
- LB addr 0x103 rdata 0x123456F0 → 0xFFFFFFF0; LBU → 0x000000F0; LH addr 0x102 rdata 0x1234_8001 → 0xFFFF8001.
- SB addr 0x101 data 0x000000AB, ack delayed 3 cycles → addr 0x100, wdata 0xABABABAB, be 4'b0100, req held 3 cycles, Stall high 3 cycles then low in ack cycle.
- LW addr 0x102 → no req, Misaligned_OUT 1 cycle, RegWrite1_OUT=0.
- RESET low during BUSY → req drops immediately, all outputs 0; after release, next LW runs normally.
